// File: rtl/bsg_nonsynth_dramsim3_chan_arb.sv
// Round-robin arbiter that shares one DRAM channel among num_req_p requesters.
// Read requester IDs are queued in issue order so that in-order read returns
// are steered back to the requester that issued them.
module bsg_nonsynth_dramsim3_chan_arb #(
  parameter int unsigned num_req_p            = 4,
  parameter int unsigned channel_addr_width_p = 29,
  parameter int unsigned data_width_p         = 512,
  parameter int unsigned max_out_p            = 8,
  localparam int unsigned data_mask_width_lp  = data_width_p / 8,
  localparam int unsigned out_width_lp        = $clog2(max_out_p + 1)
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,

  input  logic [num_req_p-1:0]                          req_v_i,
  input  logic [num_req_p-1:0]                          req_write_not_read_i,
  input  logic [num_req_p*channel_addr_width_p-1:0]     req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]             req_data_i,
  input  logic [num_req_p*data_mask_width_lp-1:0]       req_mask_i,
  output logic [num_req_p-1:0]                          req_yumi_o,

  output logic                                          ch_v_o,
  output logic                                          ch_write_not_read_o,
  output logic [channel_addr_width_p-1:0]               ch_addr_o,
  output logic [data_width_p-1:0]                       ch_data_o,
  output logic [data_mask_width_lp-1:0]                 ch_mask_o,
  input  logic                                          ch_ready_i,

  input  logic                                          ch_data_v_i,
  input  logic [data_width_p-1:0]                       ch_data_i,

  output logic [num_req_p-1:0]                          resp_v_o,
  output logic [data_width_p-1:0]                       resp_data_o,
  output logic [out_width_lp-1:0]                       outstanding_o,
  output logic                                          error_o
);

  localparam int unsigned IW = $clog2(num_req_p);
  localparam int unsigned FW = $clog2(max_out_p);
  localparam logic [out_width_lp-1:0] MAX_CNT = out_width_lp'(max_out_p);

  logic [IW-1:0]           ptr_q, ptr_d;
  logic [FW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [out_width_lp-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [IW-1:0]           id_mem_q [max_out_p];

  logic [num_req_p-1:0]    elig;
  logic                    any_elig;
  logic [IW-1:0]           sel;
  logic                    xfer;
  logic                    push;
  logic                    pop;
  logic [IW-1:0]           head_id;

  // Eligibility: writes always; reads only if a slot is free now or a return
  // this cycle frees one (push and pop then cancel).
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      elig[i] = req_v_i[i] & (req_write_not_read_i[i] | (cnt_q < MAX_CNT) | ch_data_v_i);
    end
  end

  // Round-robin pick: first eligible requester at or above the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    any_elig = 1'b0;
    sel      = '0;
    idx      = 0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        sel      = IW'(idx);
      end
    end
  end

  // Channel request mux, handshake and read-return steering; all gated by reset.
  always_comb begin
    ch_v_o              = reset_n_i & any_elig;
    ch_write_not_read_o = req_write_not_read_i[sel];
    ch_addr_o           = req_addr_i[sel*channel_addr_width_p +: channel_addr_width_p];
    ch_data_o           = req_data_i[sel*data_width_p +: data_width_p];
    ch_mask_o           = req_mask_i[sel*data_mask_width_lp +: data_mask_width_lp];

    xfer       = ch_v_o & ch_ready_i;
    push       = xfer & ~req_write_not_read_i[sel];
    pop        = reset_n_i & ch_data_v_i & (cnt_q != '0);
    head_id    = id_mem_q[rd_ptr_q];

    req_yumi_o      = '0;
    req_yumi_o[sel] = xfer;
    resp_v_o        = '0;
    resp_v_o[head_id] = pop;
    resp_data_o     = ch_data_i;

    outstanding_o = cnt_q;
    error_o       = err_q;
  end

  // Next-state: pointer advance past the winner, FIFO pointers/count, sticky error.
  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (xfer) ptr_d = (sel == IW'(num_req_p - 1)) ? '0 : sel + IW'(1);

    // Pointers are log2(max_out_p) bits wide, so natural overflow is the wrap.
    if (push) wr_ptr_d = wr_ptr_q + FW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FW'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + out_width_lp'(1);
      2'b01:   cnt_d = cnt_q - out_width_lp'(1);
      default: cnt_d = cnt_q;
    endcase

    if (ch_data_v_i && (cnt_q == '0)) err_d = 1'b1;
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // ID storage; contents are meaningless while the count says empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_chan_arb.sv
// Directed bench for the DRAM channel arbiter: a vector table for the basic
// round-robin/return flow plus hand sequences for capacity, ordering and reset.
module tb_bsg_nonsynth_dramsim3_chan_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 29;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned MO = 8;
  localparam int unsigned OW = $clog2(MO + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_v, req_w, yumi, resp_v;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR*MW-1:0]  req_mask;
  logic              ch_v, ch_w, ch_ready, ch_dv, err;
  logic [AW-1:0]     ch_addr;
  logic [DW-1:0]     ch_data, ch_rdata, resp_data;
  logic [MW-1:0]     ch_mask;
  logic [OW-1:0]     outs;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bsg_nonsynth_dramsim3_chan_arb #(
    .num_req_p(NR), .channel_addr_width_p(AW), .data_width_p(DW), .max_out_p(MO)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(req_v), .req_write_not_read_i(req_w), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_mask_i(req_mask), .req_yumi_o(yumi),
    .ch_v_o(ch_v), .ch_write_not_read_o(ch_w), .ch_addr_o(ch_addr),
    .ch_data_o(ch_data), .ch_mask_o(ch_mask), .ch_ready_i(ch_ready),
    .ch_data_v_i(ch_dv), .ch_data_i(ch_rdata),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .outstanding_o(outs), .error_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] w;
    logic       rdy;
    logic       dv;
    logic [3:0] yumi;
    logic       chv;
    logic [1:0] sel;
    logic [3:0] resp;
    logic [3:0] outs;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_v = '0; req_w = '0; ch_ready = 1'b0; ch_dv = 1'b0; ch_rdata = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_v = '0; req_w = '0; ch_ready = 1'b0; ch_dv = 1'b0; ch_rdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = AW'(32'h100 + i);
      req_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      req_mask[i*MW +: MW] = MW'(i + 1);
    end

    //            v      w      rdy   dv    yumi   chv   sel   resp   outs
    vecs[0]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0, 4'd0};
    vecs[1]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 4'h0, 4'd1};
    vecs[2]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h4, 1'b1, 2'd2, 4'h0, 4'd2};
    vecs[3]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h8, 1'b1, 2'd3, 4'h0, 4'd3};
    vecs[4]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0, 4'h0, 4'd4};
    vecs[5]  = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 4'd5};
    vecs[6]  = '{4'h2, 4'h2, 1'b0, 1'b1, 4'h0, 1'b1, 2'd1, 4'h2, 4'd4};
    vecs[7]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h2, 1'b1, 2'd1, 4'h0, 4'd3};
    vecs[8]  = '{4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 4'h4, 4'd3};
    vecs[9]  = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h8, 4'd3};
    vecs[10] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 4'd2};
    vecs[11] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h1, 4'd1};
    vecs[12] = '{4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 4'd0};

    // Reset state, with requests and a return pending to show they are masked.
    req_v = 4'hF; ch_ready = 1'b1; ch_dv = 1'b1;
    #3;
    chk("rst_yumi", yumi, 0);
    chk("rst_chv", ch_v, 0);
    chk("rst_resp", resp_v, 0);
    chk("rst_outs", outs, 0);
    chk("rst_err", err, 0);
    do_reset();

    // Table: round-robin reads, returns, write under not-ready, push+pop together.
    for (int r = 0; r < 13; r++) begin
      req_v    = vecs[r].v;
      req_w    = vecs[r].w;
      ch_ready = vecs[r].rdy;
      ch_dv    = vecs[r].dv;
      ch_rdata = 32'hA500_0000 + 32'(r);
      #3;
      chk($sformatf("v%0d_yumi", r), yumi, vecs[r].yumi);
      chk($sformatf("v%0d_chv", r), ch_v, vecs[r].chv);
      chk($sformatf("v%0d_resp", r), resp_v, vecs[r].resp);
      chk($sformatf("v%0d_outs", r), outs, vecs[r].outs);
      chk($sformatf("v%0d_err", r), err, 0);
      if (vecs[r].chv) begin
        chk($sformatf("v%0d_addr", r), ch_addr, 32'h100 + vecs[r].sel);
        chk($sformatf("v%0d_wnr", r), ch_w, vecs[r].w[vecs[r].sel]);
        chk($sformatf("v%0d_data", r), ch_data, 32'hD000_0000 + vecs[r].sel);
        chk($sformatf("v%0d_mask", r), ch_mask, vecs[r].sel + 1);
      end
      if (vecs[r].resp != 4'h0) chk($sformatf("v%0d_rdata", r), resp_data, 32'hA500_0000 + 32'(r));
      tick();
    end

    // Return ordering: reads from 1, 3, 0 come back in that order.
    do_reset();
    req_w = '0; ch_ready = 1'b1;
    req_v = 4'b0010; #3; chk("ord_g1", yumi, 4'b0010); tick();
    req_v = 4'b1000; #3; chk("ord_g3", yumi, 4'b1000); tick();
    req_v = 4'b0001; #3; chk("ord_g0", yumi, 4'b0001); tick();
    req_v = '0; ch_dv = 1'b1;
    ch_rdata = 32'h1111_1111; #3;
    chk("ord_r1", resp_v, 4'b0010); chk("ord_d1", resp_data, 32'h1111_1111); tick();
    ch_rdata = 32'h2222_2222; #3;
    chk("ord_r3", resp_v, 4'b1000); chk("ord_d3", resp_data, 32'h2222_2222); tick();
    ch_rdata = 32'h3333_3333; #3;
    chk("ord_r0", resp_v, 4'b0001); chk("ord_d0", resp_data, 32'h3333_3333); tick();
    ch_dv = 1'b0; #3;
    chk("ord_outs", outs, 0); chk("ord_err", err, 0);

    // Capacity: 8 reads fill, 9th blocked, other write passes, push+pop when full.
    do_reset();
    req_w = '0; ch_ready = 1'b1; req_v = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      #3; chk($sformatf("full_g%0d", k), yumi, 4'b0100); tick();
    end
    #3;
    chk("full_outs", outs, 8);
    chk("full_yumi", yumi, 0);
    chk("full_chv", ch_v, 0);
    tick();
    req_v = 4'b0110; req_w = 4'b0010; #3;
    chk("full_wr_yumi", yumi, 4'b0010);
    chk("full_wr_wnr", ch_w, 1);
    chk("full_wr_addr", ch_addr, 32'h101);
    tick();
    req_v = 4'b1000; req_w = '0; ch_dv = 1'b1; ch_rdata = 32'hCAFE_0001; #3;
    chk("pp_yumi", yumi, 4'b1000);
    chk("pp_resp", resp_v, 4'b0100);
    chk("pp_rdata", resp_data, 32'hCAFE_0001);
    tick();
    req_v = '0; ch_dv = 1'b0; #3;
    chk("pp_outs", outs, 8);
    chk("pp_err", err, 0);

    // Spurious return: sticky error until reset.
    do_reset();
    ch_dv = 1'b1; #3;
    chk("sp_resp", resp_v, 0);
    chk("sp_err0", err, 0);
    tick();
    ch_dv = 1'b0; #3;
    chk("sp_err1", err, 1);
    chk("sp_outs", outs, 0);
    tick(); tick(); #3;
    chk("sp_hold", err, 1);
    rst_n = 1'b0; #1;
    chk("sp_clr", err, 0);
    tick();

    // Mid-operation reset discards outstanding IDs and restarts the pointer.
    do_reset();
    req_v = 4'b0111; req_w = '0; ch_ready = 1'b1;
    tick(); tick(); tick();
    req_v = 4'hF; ch_ready = 1'b0; #3;
    chk("mr_outs3", outs, 3);
    ch_ready = 1'b1; ch_dv = 1'b1;
    rst_n = 1'b0; #1;
    chk("mr_yumi", yumi, 0);
    chk("mr_chv", ch_v, 0);
    chk("mr_resp", resp_v, 0);
    chk("mr_outs0", outs, 0);
    chk("mr_err", err, 0);
    tick();
    rst_n = 1'b1; ch_dv = 1'b0; #3;
    chk("mr_g0", yumi, 4'b0001);
    tick();
    req_v = '0; #3;
    chk("mr_outs1", outs, 1);
    ch_dv = 1'b1; #1;
    chk("mr_ret", resp_v, 4'b0001);
    tick();
    ch_dv = 1'b0; #3;
    chk("mr_err_after", err, 0);
    chk("mr_outs_end", outs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_nonsynth_dramsim3_chan_arb.md
BSG_NONSYNTH_DRAMSIM3_CHAN_ARB -- requirements
Module: bsg_nonsynth_dramsim3_chan_arb

Interface
REQ-001 SHALL have parameter num_req_p, default 4: number of requesters sharing one DRAM channel (2..16).
REQ-002 SHALL have parameter channel_addr_width_p, default 29: channel-local byte address width.
REQ-003 SHALL have parameter data_width_p, default 512: DRAM data width; data_mask_width_lp = data_width_p/8.
REQ-004 SHALL have parameter max_out_p, default 8: maximum outstanding reads (power of 2, >=2).
REQ-005 SHALL have ports, one per line:
- clk_i  in  1  sole clock; all state on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- req_v_i  in  num_req_p  per-requester request valid
- req_write_not_read_i  in  num_req_p  1 = write, 0 = read
- req_addr_i  in  num_req_p*channel_addr_width_p  packed addresses, requester 0 in LSBs
- req_data_i  in  num_req_p*data_width_p  packed write data
- req_mask_i  in  num_req_p*data_mask_width_lp  packed write byte masks
- req_yumi_o  out  num_req_p  one-hot accept of requester's request
- ch_v_o  out  1  request valid toward channel
- ch_write_not_read_o  out  1  selected command type
- ch_addr_o  out  channel_addr_width_p  selected address
- ch_data_o  out  data_width_p  selected write data
- ch_mask_o  out  data_mask_width_lp  selected mask
- ch_ready_i  in  1  channel accepts request this cycle
- ch_data_v_i  in  1  channel read data return (in issue order)
- ch_data_i  in  data_width_p  read return data
- resp_v_o  out  num_req_p  one-hot read return to requester
- resp_data_o  out  data_width_p  broadcast read data
- outstanding_o  out  $clog2(max_out_p+1)  current outstanding read count
- error_o  out  1  sticky protocol error

Function
REQ-006 SHALL treat requester i as eligible when req_v_i[i]=1 and (write, or outstanding count < max_out_p, or ch_data_v_i=1 this cycle).
REQ-007 SHALL select the first eligible requester scanning upward from the round-robin pointer, wrapping num_req_p-1 -> 0.
REQ-008 SHALL drive ch_v_o=1 iff any requester eligible; ch_* fields from the selected requester, combinationally.
REQ-009 SHALL assert req_yumi_o[sel]=1 only when ch_v_o & ch_ready_i; at most one yumi bit per cycle; transfer occurs that cycle.
REQ-010 SHALL, on a transfer, update pointer to (sel+1) mod num_req_p at next edge; no transfer -> pointer unchanged.
REQ-011 SHALL, on a read transfer, push sel into an ID FIFO of depth max_out_p (outstanding +1).
REQ-012 SHALL, on ch_data_v_i with FIFO non-empty, pop head ID and drive resp_v_o one-hot at that ID and resp_data_o=ch_data_i the same cycle (zero latency, outstanding -1).
REQ-013 SHALL handle push and pop in the same cycle including when full: outstanding unchanged, ordering preserved.
REQ-014 SHALL, on ch_data_v_i with FIFO empty, set error_o=1 (sticky until reset), resp_v_o=0, outstanding stays 0.
REQ-015 SHALL never admit a read that would make outstanding exceed max_out_p; blocked reads do not block eligible writes from other requesters.
REQ-016 SHALL not require requester valid to hold; a request withdrawn before yumi is simply not transferred.
REQ-017 SHALL keep FIFO pointers wrapping modulo max_out_p.

Reset
REQ-018 SHALL, while reset_n_i=0, asynchronously force pointer=0, FIFO empty, outstanding_o=0, error_o=0.
REQ-019 SHALL, during reset, drive req_yumi_o=0, ch_v_o=0, resp_v_o=0 regardless of inputs.
REQ-020 SHALL, on reset asserted mid-operation, discard all outstanding IDs; returns after release with empty FIFO follow REQ-014.

Verification
REQ-021 All four requesters assert reads, ch_ready_i=1 every cycle -> grants 0,1,2,3,0; outstanding_o 1,2,3,4,5.
REQ-022 max_out_p=8, requester 2 issues 8 reads, no returns -> outstanding_o=8, 9th read gets no yumi; requester 1 write still granted.
REQ-023 Outstanding=8, ch_data_v_i=1 same cycle as requester 3 read -> read granted, resp_v_o=4'b0100 (head ID 2), outstanding_o stays 8.
REQ-024 Reads issued by IDs 1,3,0 -> three returns produce resp_v_o 0010, 1000, 0001 with matching ch_data_i.
REQ-025 ch_data_v_i=1 after reset with no reads -> error_o=1 next cycle, resp_v_o=0, holds until reset_n_i=0.
REQ-026 reset_n_i pulled low with 3 outstanding, ch_ready_i=0 -> outputs zero immediately; after release outstanding_o=0, pointer grants requester 0 first.
